// File: rtl/clk_sync_low_to_high_rx_pkg.sv
// Shared types and defaults for the req/ack receiver that brings events
// from a slow asynchronous source into the fast clock domain.
package clk_sync_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } sync_rx_state_t;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_ACK  = ACK;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_sync_low_to_high_rx_sync_fifo.sv
// Small circular-buffer FIFO with occupancy counter; head entry is always
// visible on head_data. Push is refused when full and pop when empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DATA_WIDTH-1:0]        head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  push_s;
    logic                  pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_s    = push & ~full;
    assign pop_s     = pop & ~empty;
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/clk_sync_low_to_high_rx.sv
// Receiving end of a 4-phase req/ack crossing: synchronizes the request,
// queues the payload, and withholds ack while the queue is full.
module clk_sync_low_to_high_rx
    import clk_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_async,
    input  logic [DATA_WIDTH-1:0]        data_async,
    output logic                         ack,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic [0:0]             state_r;
    logic [0:0]             state_next;
    logic                   push_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   ack_r;

    // Request synchronizer; data_async is sampled unsynchronized because the
    // protocol keeps it stable for the whole time req_s can read 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_async};
        end
    end

    assign req_s = sync_r[SYNC_STAGES-1];

    // Next-state and push decode; one push per request pulse.
    always_comb begin
        state_next = state_r;
        push_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !full_s) begin
                    push_s     = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_ACK;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_next;
            ack_r   <= (state_next == ST_ACK);
        end
    end

    assign ack       = ack_r;
    assign out_valid = ~empty_s;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (data_async),
        .pop       (out_ready & ~empty_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count),
        .head_data (out_data)
    );

endmodule

// File: tb/tb_clk_sync_low_to_high_rx.sv
// Directed bench for clk_sync_low_to_high_rx: a 4-phase source model drives
// requests, and every accepted output word is checked against a send-order queue.
module tb_clk_sync_low_to_high_rx;

    logic       clk;
    logic       rst_n;
    logic       req_async;
    logic [7:0] data_async;
    logic       ack;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;

    int         n_asserts;
    int         n_fail;
    int         pops;
    int         pops_before;
    bit         toggle_mode;
    logic [7:0] exp_q[$];

    clk_sync_low_to_high_rx #(
        .DATA_WIDTH  (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks any pop about to happen at the next edge, then advances one cycle.
    task automatic tick();
        logic [7:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = 8'hxx;
            end
            check("pop_data", {24'h0, out_data}, {24'h0, e});
            pops++;
        end
        @(posedge clk);
        #1;
        if (toggle_mode) out_ready = ~out_ready;
    endtask

    task automatic wait_ack(input logic v);
        int n;
        n = 0;
        while (ack !== v && n < 60) begin
            tick();
            n++;
        end
        check("ack_wait", {31'h0, ack}, {31'h0, v});
    endtask

    task automatic send(input logic [7:0] d);
        exp_q.push_back(d);
        data_async = d;
        req_async  = 1'b1;
        wait_ack(1'b1);
        req_async  = 1'b0;
        wait_ack(1'b0);
    endtask

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        pops        = 0;
        toggle_mode = 1'b0;
        rst_n       = 1'b0;
        req_async   = 1'b0;
        data_async  = 8'h00;
        out_ready   = 1'b0;
        @(posedge clk); #1;
        tick(); tick();
        check("rst_ack",       {31'h0, ack},       32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data",  {24'h0, out_data},  32'h0);
        check("rst_count",     {29'h0, count},     32'h0);
        rst_n = 1'b1;
        tick();

        // Single event, checked cycle by cycle.
        exp_q.push_back(8'hA5);
        data_async = 8'hA5;
        req_async  = 1'b1;
        tick(); tick();
        check("single_no_push_yet", {29'h0, count}, 32'h0);
        check("single_ack_low",     {31'h0, ack},   32'h0);
        tick();
        check("single_ack",       {31'h0, ack},       32'h1);
        check("single_count",     {29'h0, count},     32'h1);
        check("single_out_valid", {31'h0, out_valid}, 32'h1);
        check("single_out_data",  {24'h0, out_data},  32'hA5);
        req_async = 1'b0;
        tick(); tick();
        check("single_ack_hold", {31'h0, ack}, 32'h1);
        tick();
        check("single_ack_drop", {31'h0, ack}, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drained", {29'h0, count}, 32'h0);
        check("single_empty",   {31'h0, out_valid}, 32'h0);

        // Burst of four with the consumer always ready.
        out_ready   = 1'b1;
        pops_before = pops;
        for (int i = 1; i <= 4; i++) send(8'(i));
        tick(); tick();
        check("burst_count", {29'h0, count}, 32'h0);
        check("burst_pops",  32'(pops - pops_before), 32'd4);
        check("burst_queue", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;

        // Full backpressure: fifth request withheld until a slot frees.
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("full_count", {29'h0, count}, 32'h4);
        exp_q.push_back(8'h55);
        data_async = 8'h55;
        req_async  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("full_ack_withheld", {31'h0, ack},   32'h0);
        check("full_count_hold",   {29'h0, count}, 32'h4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_bubble_count", {29'h0, count}, 32'h3);
        check("full_bubble_ack",   {31'h0, ack},   32'h0);
        tick();
        check("full_push_count", {29'h0, count}, 32'h4);
        check("full_push_ack",   {31'h0, ack},   32'h1);
        exp_q.pop_back();
        exp_q.push_back(8'h55);
        req_async = 1'b0;
        wait_ack(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        check("full_drained", {29'h0, count}, 32'h0);

        // Wrap-around with a toggling consumer.
        out_ready   = 1'b1;
        toggle_mode = 1'b1;
        pops_before = pops;
        for (int i = 0; i < 10; i++) send(8'(i));
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        toggle_mode = 1'b0;
        out_ready   = 1'b0;
        tick();
        check("wrap_pops",  32'(pops - pops_before), 32'd10);
        check("wrap_queue", 32'(exp_q.size()), 32'd0);
        check("wrap_count", {29'h0, count}, 32'h0);

        // Simultaneous push and pop at count 2.
        send(8'h10);
        send(8'h20);
        check("sim_count_pre", {29'h0, count}, 32'h2);
        exp_q.push_back(8'h30);
        data_async = 8'h30;
        req_async  = 1'b1;
        tick(); tick();
        check("sim_count_wait", {29'h0, count}, 32'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sim_count",    {29'h0, count},    32'h2);
        check("sim_head",     {24'h0, out_data}, 32'h20);
        check("sim_ack",      {31'h0, ack},      32'h1);
        req_async = 1'b0;
        wait_ack(1'b0);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        check("sim_drained", {29'h0, count}, 32'h0);

        // Reset while in ACK with three entries queued and req still high.
        send(8'h01);
        send(8'h02);
        exp_q.push_back(8'h33);
        data_async = 8'h33;
        req_async  = 1'b1;
        wait_ack(1'b1);
        check("rst_mid_count_pre", {29'h0, count}, 32'h3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_count", {29'h0, count},     32'h0);
        check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        check("rst_mid_ack",   {31'h0, ack},       32'h0);
        exp_q.delete();
        exp_q.push_back(8'h33);
        tick(); tick();
        check("recap_wait", {29'h0, count}, 32'h0);
        tick();
        check("recap_count", {29'h0, count},    32'h1);
        check("recap_ack",   {31'h0, ack},      32'h1);
        check("recap_data",  {24'h0, out_data}, 32'h33);
        req_async = 1'b0;
        wait_ack(1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("recap_drained", {29'h0, count}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
